// File: rtl/core_seq_pkg.sv
// Shared types for the core sequencer: FSM state encoding and memory-select values.
package core_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6
    } state_e;

    localparam logic MEM_SEL_FETCH = 1'b0;  // instruction fetch at PC
    localparam logic MEM_SEL_DATA  = 1'b1;  // data access at ALU result

endpackage

// File: rtl/core_sequencer_if.sv
// Shared memory port between the sequencer (master) and the memory (slave).
interface core_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_sel;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output mem_sel, input mem_ack);
    modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ack);
endinterface

// File: rtl/seq_timeout_counter.sv
// Memory-ack wait counter; only built when CORE_SEQ_MEM_TIMEOUT_EN is defined.
// expired is asserted during the TIMEOUT_CYCLES-th consecutive enabled cycle.
module seq_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] count;

    // count enabled wait cycles, restarting whenever cleared
    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 8'd1;
    end

    assign expired = enable && (count == 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle core control sequencer: IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT.
// Optional memory-ack timeout enabled with macro CORE_SEQ_MEM_TIMEOUT_EN.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    should_read_mem,
    input  logic                    should_write_mem,
    input  logic                    should_write_reg,
    input  logic                    instr_illegal,
    core_sequencer_if.master        bus,
    output logic                    instr_latch_en,
    output logic                    mem_data_latch_en,
    output logic                    reg_write_en,
    output logic                    pc_update_en,
    output logic                    halted,
    output logic                    bus_err,
    output logic [2:0]              state,
    output logic [31:0]             retired_count
);
    state_e      state_q, state_d;
    logic        rd_q, wr_q, wreg_q;
    logic        req, we, sel;
    logic        waiting;
    logic        timeout;
    logic [31:0] retired_q;

    assign waiting = (state_q == FETCH) || (state_q == MEMORY);

`ifdef CORE_SEQ_MEM_TIMEOUT_EN
    logic err_q;

    // counter restarts outside the wait states and on every ack, so it is zero on entry
    seq_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!waiting || bus.mem_ack),
        .enable  (waiting),
        .expired (timeout)
    );

    // sticky bus error, set when a wait state gives up without an ack
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (waiting && !bus.mem_ack && timeout)
            err_q <= 1'b1;
    end
    assign bus_err = err_q;
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // decoder flags captured in DECODE for use in EXECUTE/MEMORY
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            wreg_q <= 1'b0;
        end else if (state_q == DECODE) begin
            rd_q   <= should_read_mem;
            wr_q   <= should_write_mem;
            wreg_q <= should_write_reg;
        end
    end

    // next state and single-cycle strobes; ack takes priority over timeout
    always_comb begin
        state_d           = state_q;
        req               = 1'b0;
        we                = 1'b0;
        sel               = MEM_SEL_FETCH;
        instr_latch_en    = 1'b0;
        mem_data_latch_en = 1'b0;
        reg_write_en      = 1'b0;
        pc_update_en      = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                req = 1'b1;
                sel = MEM_SEL_FETCH;
                if (bus.mem_ack) begin
                    instr_latch_en = 1'b1;
                    state_d        = DECODE;
                end else if (timeout) begin
                    state_d = HALT;
                end
            end
            DECODE: begin
                if (instr_illegal || (should_read_mem && should_write_mem))
                    state_d = HALT;
                else
                    state_d = EXECUTE;
            end
            EXECUTE: begin
                if (rd_q || wr_q)
                    state_d = MEMORY;
                else if (wreg_q)
                    state_d = WRITEBACK;
                else begin
                    pc_update_en = 1'b1;
                    state_d      = FETCH;
                end
            end
            MEMORY: begin
                req = 1'b1;
                sel = MEM_SEL_DATA;
                we  = wr_q;
                if (bus.mem_ack) begin
                    if (wr_q) begin
                        pc_update_en = 1'b1;
                        state_d      = FETCH;
                    end else begin
                        mem_data_latch_en = 1'b1;
                        state_d           = WRITEBACK;
                    end
                end else if (timeout) begin
                    state_d = HALT;
                end
            end
            WRITEBACK: begin
                reg_write_en = 1'b1;
                pc_update_en = 1'b1;
                state_d      = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n)
            retired_q <= '0;
        else if (pc_update_en)
            retired_q <= retired_q + 32'd1;
    end

    assign bus.mem_req    = req;
    assign bus.mem_we     = we;
    assign bus.mem_sel    = sel;
    assign halted         = (state_q == HALT);
    assign state          = state_q;
    assign retired_count  = retired_q;
endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16; memory-ack wait limit in cycles, legal range 1..255.
REQ-002 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 Ports: should_read_mem, should_write_mem, should_write_reg  in  1 each  decoder flags for the latched instruction.
REQ-005 Port: instr_illegal  in  1  decoder reports an unsupported opcode.
REQ-006 Ports: mem_req, mem_we, mem_sel  out  1 each  shared memory port; mem_sel 0 = fetch at PC, 1 = data at ALU result.
REQ-007 Port: mem_ack  in  1  memory completes the current request.
REQ-008 Ports: instr_latch_en, mem_data_latch_en, reg_write_en, pc_update_en  out  1 each  single-cycle datapath strobes.
REQ-009 Ports: halted, bus_err  out  1 each; state  out  3  debug; retired_count  out  32  retired-instruction count.

Function
REQ-010 The FSM SHALL have states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
REQ-011 IDLE SHALL move to FETCH after one cycle.
REQ-012 FETCH: mem_req=1, mem_sel=0, mem_we=0; on mem_ack, pulse instr_latch_en that cycle and go to DECODE.
REQ-013 DECODE SHALL register the three decoder flags; go to HALT if instr_illegal, or if should_read_mem and should_write_mem are both 1; otherwise go to EXECUTE.
REQ-014 EXECUTE: registered read or write flag -> MEMORY; else write_reg -> WRITEBACK; else pulse pc_update_en and go to FETCH.
REQ-015 MEMORY: mem_req=1, mem_sel=1, mem_we=registered write flag; on ack, a read pulses mem_data_latch_en and goes to WRITEBACK, and a write pulses pc_update_en and goes to FETCH.
REQ-016 WRITEBACK SHALL pulse reg_write_en and pc_update_en together, then go to FETCH.
REQ-017 mem_req SHALL stay high with mem_sel and mem_we stable until the cycle mem_ack is seen; an ack in the first req cycle is legal (zero-wait).
REQ-018 mem_ack SHALL be ignored while mem_req=0.
REQ-019 Zero-wait latencies: ALU/LUI/JAL 4 cycles, load 5, store 4, branch/fence 3 (FETCH to next FETCH).
REQ-020 retired_count SHALL increment by 1 on every pc_update_en pulse and wrap from 0xFFFFFFFF to 0.
REQ-021 HALT: halted=1, all strobes and mem_req 0; exit only by reset.
REQ-022 state SHALL expose the current encoding.

Reset
REQ-023 With rst_n=0 at a clock edge: state=IDLE, all strobes 0, mem_req 0, mem_we 0, mem_sel 0, halted 0, bus_err 0, retired_count 0, registered flags 0.
REQ-024 Reset mid-request SHALL drop mem_req on the next edge; a late ack SHALL then be ignored.

Configuration
REQ-025 Macro CORE_SEQ_MEM_TIMEOUT_EN defined: a wait counter clears on entry to FETCH or MEMORY; if TIMEOUT_CYCLES cycles elapse without mem_ack, the FSM goes to HALT and sets bus_err=1, sticky until reset.
REQ-026 Macro undefined: the FSM waits indefinitely for mem_ack; bus_err is tied to 0; no counter logic exists.

Structure
REQ-027 Package core_seq_pkg SHALL hold the state enum (3-bit) and the mem_sel encodings MEM_SEL_FETCH and MEM_SEL_DATA.
REQ-028 Sub-module seq_timeout_counter (clear, enable, expired; parameter TIMEOUT_CYCLES) SHALL be instantiated only under CORE_SEQ_MEM_TIMEOUT_EN.

Verification
REQ-029 ADD-type flags (write_reg=1), zero-wait ack -> state sequence FETCH,DECODE,EXECUTE,WRITEBACK; reg_write_en and pc_update_en high in cycle 4; retired_count=1.
REQ-030 Load flags, ack delayed 3 cycles in MEMORY -> mem_req held 3 cycles with mem_sel=1 and mem_we=0; mem_data_latch_en on the ack cycle; WRITEBACK follows.
REQ-031 Store flags, zero-wait -> mem_we=1 in MEMORY, no reg_write_en, pc_update_en on the ack cycle, 4 cycles total.
REQ-032 instr_illegal=1 at DECODE -> HALT next cycle; halted=1; no further mem_req for 20 cycles; retired_count unchanged.
REQ-033 Timeout macro defined, TIMEOUT_CYCLES=4, no ack in FETCH -> HALT with bus_err=1 after 4 cycles; macro undefined -> mem_req still high after 100 cycles.
REQ-034 retired_count preset to 0xFFFFFFFF via 2^32-1 retirements or force, one more retirement -> 0; rst_n low during a MEMORY wait -> IDLE with mem_req=0 on the next edge.
